// File: rtl/rpn_stack_ctrl.sv
// rpn_stack_ctrl: reverse-Polish evaluator driving an external stack_memory.
// Optional feature: define RPN_MUL_EN to build opcode 6 as MUL (otherwise it is illegal).
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | waiting for a token, performs acceptance/error checks
// S_PUSH     | stk_push high with operand or result on stk_din
// S_POP_B    | first pop of a binary op (top of stack, B)
// S_POP_A    | second pop; B is captured from stk_dout
// S_CAP_A    | A on stk_dout, result computed and push scheduled
// S_EMIT_POP | stk_pop high for EMIT
// S_EMIT_CAP | popped value captured into res_data
// S_EMIT_OUT | res_valid held until res_ready
module rpn_stack_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int STACK_DEPTH = 16,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tok_valid,
  output logic                  tok_ready,
  input  logic                  tok_is_op,
  input  logic [DATA_WIDTH-1:0] tok_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [DATA_WIDTH-1:0] stk_din,
  input  logic [DATA_WIDTH-1:0] stk_dout,
  output logic [ADDR_WIDTH:0]   depth,
  output logic                  err,
  output logic [1:0]            err_code,
  input  logic                  err_clr
);

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH, S_POP_B, S_POP_A, S_CAP_A, S_EMIT_POP, S_EMIT_CAP, S_EMIT_OUT
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_EMIT = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;

  localparam logic [1:0] ERR_UNDER   = 2'd1;
  localparam logic [1:0] ERR_OVER    = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL = 2'd3;

  localparam logic [ADDR_WIDTH:0] DEPTH_FULL = (ADDR_WIDTH+1)'(STACK_DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_TWO  = (ADDR_WIDTH+1)'(2);
  localparam logic [ADDR_WIDTH:0] DEPTH_ONE  = (ADDR_WIDTH+1)'(1);

  state_t                state_q, state_d;
  logic                  tok_ready_q, tok_ready_d;
  logic                  stk_push_q, stk_push_d;
  logic                  stk_pop_q, stk_pop_d;
  logic [DATA_WIDTH-1:0] stk_din_q, stk_din_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [2:0]            op_q, op_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic [ADDR_WIDTH:0]   depth_q, depth_d;
  logic                  err_q, err_d;
  logic [1:0]            err_code_q, err_code_d;
  logic                  new_err;
  logic [1:0]            new_code;

  function automatic logic [DATA_WIDTH-1:0] alu(input logic [2:0] op,
                                                input logic [DATA_WIDTH-1:0] a,
                                                input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
`ifdef RPN_MUL_EN
      OP_MUL:  r = a * b;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  // Next-state, strobe, depth and error-flag logic
  always_comb begin
    state_d     = state_q;
    stk_push_d  = 1'b0;
    stk_pop_d   = 1'b0;
    stk_din_d   = stk_din_q;
    b_d         = b_q;
    op_d        = op_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    new_err     = 1'b0;
    new_code    = 2'd0;

    case (state_q)
      S_IDLE: begin
        if (tok_valid && tok_ready_q) begin
          if (!tok_is_op) begin
            if (depth_q == DEPTH_FULL) begin
              new_err  = 1'b1;
              new_code = ERR_OVER;
            end else begin
              stk_push_d = 1'b1;
              stk_din_d  = tok_data;
              state_d    = S_PUSH;
            end
          end else begin
            case (tok_data[2:0])
              OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR
`ifdef RPN_MUL_EN
              , OP_MUL
`endif
              : begin
                if (depth_q < DEPTH_TWO) begin
                  new_err  = 1'b1;
                  new_code = ERR_UNDER;
                end else begin
                  op_d      = tok_data[2:0];
                  stk_pop_d = 1'b1;
                  state_d   = S_POP_B;
                end
              end
              OP_EMIT: begin
                if (depth_q == '0) begin
                  new_err  = 1'b1;
                  new_code = ERR_UNDER;
                end else begin
                  stk_pop_d = 1'b1;
                  state_d   = S_EMIT_POP;
                end
              end
              default: begin
                new_err  = 1'b1;
                new_code = ERR_ILLEGAL;
              end
            endcase
          end
        end
      end
      S_PUSH:  state_d = S_IDLE;
      S_POP_B: begin
        stk_pop_d = 1'b1;
        state_d   = S_POP_A;
      end
      S_POP_A: begin
        b_d     = stk_dout;
        state_d = S_CAP_A;
      end
      S_CAP_A: begin
        stk_push_d = 1'b1;
        stk_din_d  = alu(op_q, stk_dout, b_q);
        state_d    = S_PUSH;
      end
      S_EMIT_POP: state_d = S_EMIT_CAP;
      S_EMIT_CAP: begin
        res_data_d  = stk_dout;
        res_valid_d = 1'b1;
        state_d     = S_EMIT_OUT;
      end
      S_EMIT_OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Depth follows the strobes so it always matches the attached stack
    depth_d = depth_q;
    if (stk_push_d)     depth_d = depth_q + DEPTH_ONE;
    else if (stk_pop_d) depth_d = depth_q - DEPTH_ONE;

    // A fresh error overrides a simultaneous clear
    err_d      = err_q;
    err_code_d = err_code_q;
    if (err_clr) begin
      err_d      = 1'b0;
      err_code_d = 2'd0;
    end
    if (new_err) begin
      err_d      = 1'b1;
      err_code_d = new_code;
    end

    tok_ready_d = (state_d == S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      tok_ready_q <= 1'b0;
      stk_push_q  <= 1'b0;
      stk_pop_q   <= 1'b0;
      stk_din_q   <= '0;
      b_q         <= '0;
      op_q        <= 3'd0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      depth_q     <= '0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      tok_ready_q <= tok_ready_d;
      stk_push_q  <= stk_push_d;
      stk_pop_q   <= stk_pop_d;
      stk_din_q   <= stk_din_d;
      b_q         <= b_d;
      op_q        <= op_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      depth_q     <= depth_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign tok_ready = tok_ready_q;
  assign stk_push  = stk_push_q;
  assign stk_pop   = stk_pop_q;
  assign stk_din   = stk_din_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign depth     = depth_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Directed bench for rpn_stack_ctrl with a behavioural stack_memory attached.
module tb_rpn_stack_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tok_valid, tok_ready, tok_is_op;
  logic [7:0] tok_data;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic       stk_push, stk_pop;
  logic [7:0] stk_din, stk_dout;
  logic [4:0] depth;
  logic       err;
  logic [1:0] err_code;
  logic       err_clr;

  int pass_cnt = 0;
  int total_cnt = 0;
  int push_cnt = 0;
  int pop_cnt = 0;
  int overlap_cnt = 0;

  always #5 clk = ~clk;

  rpn_stack_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op), .tok_data(tok_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din), .stk_dout(stk_dout),
    .depth(depth), .err(err), .err_code(err_code), .err_clr(err_clr)
  );

  // Behavioural stack: registered read data, valid the cycle after a pop
  logic [7:0] smem [0:15];
  logic [4:0] sp;
  logic [3:0] top_idx;
  assign top_idx = sp[3:0] - 4'd1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp       <= 5'd0;
      stk_dout <= 8'd0;
    end else if (stk_push && sp < 5'd16) begin
      smem[sp[3:0]] <= stk_din;
      sp            <= sp + 5'd1;
    end else if (stk_pop && sp > 5'd0) begin
      stk_dout <= smem[top_idx];
      sp       <= sp - 5'd1;
    end
  end

  // Strobe activity counters
  always @(posedge clk) begin
    if (reset_n) begin
      if (stk_push)            push_cnt    <= push_cnt + 1;
      if (stk_pop)             pop_cnt     <= pop_cnt + 1;
      if (stk_push && stk_pop) overlap_cnt <= overlap_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic timeout_fail(input string tag);
    total_cnt++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (tok_ready !== 1'b1 && n < 50) begin cyc(); n++; end
    if (n >= 50) timeout_fail(tag);
  endtask

  // Offers one token; returns #1 into cycle 1 after the accept edge
  task automatic send(input logic is_op, input logic [7:0] d);
    wait_idle("send_ready");
    tok_valid = 1'b1;
    tok_is_op = is_op;
    tok_data  = d;
    cyc();
    tok_valid = 1'b0;
    tok_is_op = 1'b0;
    tok_data  = 8'd0;
  endtask

  task automatic push_val(input logic [7:0] d);
    send(1'b0, d);
    wait_idle("push_done");
  endtask

  task automatic do_op(input logic [2:0] code);
    send(1'b1, {5'd0, code});
    wait_idle("op_done");
  endtask

  task automatic emit(input string tag, input logic [7:0] exp);
    int n = 0;
    send(1'b1, 8'd5);
    while (res_valid !== 1'b1 && n < 50) begin cyc(); n++; end
    if (n >= 50) timeout_fail(tag);
    chk(tag, {24'd0, res_data}, {24'd0, exp});
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    wait_idle("emit_done");
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
  endtask

  int p0, q0, o0;

  initial begin
    reset_n = 1'b0; tok_valid = 1'b0; tok_is_op = 1'b0; tok_data = 8'd0;
    res_ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tok_ready", {31'd0, tok_ready}, 0);
    chk("rst_res_valid", {31'd0, res_valid}, 0);
    chk("rst_stk_push", {31'd0, stk_push}, 0);
    chk("rst_depth", {27'd0, depth}, 0);
    chk("rst_err", {29'd0, err, err_code}, 0);
    reset_n = 1'b1;
    cyc();
    chk("ready_after_rst", {31'd0, tok_ready}, 1);

    // 3 4 ADD EMIT with cycle-accurate strobe checks
    p0 = push_cnt; q0 = pop_cnt; o0 = overlap_cnt;
    send(1'b0, 8'd3);
    chk("opnd_push_c1", {31'd0, stk_push}, 1);
    chk("opnd_din_c1", {24'd0, stk_din}, 3);
    cyc();
    chk("opnd_push_c2", {31'd0, stk_push}, 0);
    chk("opnd_ready_c2", {31'd0, tok_ready}, 1);
    chk("opnd_depth", {27'd0, depth}, 1);
    push_val(8'd4);
    send(1'b1, 8'd0);
    chk("add_pop_c1", {31'd0, stk_pop}, 1);
    cyc();
    chk("add_pop_c2", {31'd0, stk_pop}, 1);
    cyc();
    chk("add_idle_c3", {30'd0, stk_push, stk_pop}, 0);
    cyc();
    chk("add_push_c4", {31'd0, stk_push}, 1);
    chk("add_din_c4", {24'd0, stk_din}, 7);
    chk("add_busy_c4", {31'd0, tok_ready}, 0);
    cyc();
    chk("add_ready_c5", {31'd0, tok_ready}, 1);
    chk("add_depth", {27'd0, depth}, 1);
    send(1'b1, 8'd5);
    chk("emit_pop_c1", {31'd0, stk_pop}, 1);
    cyc();
    chk("emit_noval_c2", {31'd0, res_valid}, 0);
    cyc();
    chk("emit_val_c3", {31'd0, res_valid}, 1);
    chk("emit_data_7", {24'd0, res_data}, 7);
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    chk("emit_val_drop", {31'd0, res_valid}, 0);
    wait_idle("emit1_done");
    chk("t1_depth", {27'd0, depth}, 0);
    chk("t1_err", {31'd0, err}, 0);
    chk("t1_pushes", push_cnt - p0, 3);
    chk("t1_pops", pop_cnt - q0, 3);
    chk("t1_overlap", overlap_cnt - o0, 0);

    // SUB wrap and XOR
    push_val(8'd2); push_val(8'd5); do_op(3'd1);
    emit("sub_wrap", 8'hFD);
    push_val(8'h0F); push_val(8'h3C); do_op(3'd4);
    emit("xor", 8'h33);
    push_val(8'hF0); push_val(8'h3C); do_op(3'd2);
    emit("and", 8'h30);
    push_val(8'hF0); push_val(8'h0C); do_op(3'd3);
    emit("or", 8'hFC);

    // Binary-op underflow leaves stack untouched
    push_val(8'd9);
    p0 = push_cnt; q0 = pop_cnt;
    send(1'b1, 8'd0);
    chk("uf_err", {29'd0, err, err_code}, {29'd0, 1'b1, 2'd1});
    wait_idle("uf_done");
    chk("uf_depth", {27'd0, depth}, 1);
    chk("uf_no_push", push_cnt - p0, 0);
    chk("uf_no_pop", pop_cnt - q0, 0);
    emit("uf_emit_9", 8'd9);
    chk("err_sticky", {31'd0, err}, 1);
    clear_err();
    chk("err_cleared", {29'd0, err, err_code}, 0);

    // EMIT on empty stack
    send(1'b1, 8'd5);
    chk("emit_empty_err", {29'd0, err, err_code}, {29'd0, 1'b1, 2'd1});
    chk("emit_empty_noval", {31'd0, res_valid}, 0);
    chk("emit_empty_depth", {27'd0, depth}, 0);

    // Illegal opcode alongside err_clr: new error wins
    err_clr = 1'b1;
    send(1'b1, 8'd7);
    err_clr = 1'b0;
    chk("clr_vs_new", {29'd0, err, err_code}, {29'd0, 1'b1, 2'd3});
    clear_err();

    // Result back-pressure
    push_val(8'h5A);
    send(1'b1, 8'd5);
    cyc(); cyc();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, res_valid}, 1);
      chk("stall_data", {24'd0, res_data}, 8'h5A);
      chk("stall_busy", {31'd0, tok_ready}, 0);
      cyc();
    end
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    chk("stall_xfer", {31'd0, res_valid}, 0);
    chk("stall_idle", {31'd0, tok_ready}, 1);

    // Opcode 6
    push_val(8'd7); push_val(8'd6); do_op(3'd6);
`ifdef RPN_MUL_EN
    chk("mul_no_err", {31'd0, err}, 0);
    emit("mul_42", 8'd42);
    chk("mul_depth", {27'd0, depth}, 0);
`else
    chk("op6_illegal", {29'd0, err, err_code}, {29'd0, 1'b1, 2'd3});
    chk("op6_depth", {27'd0, depth}, 2);
    emit("op6_top", 8'd6);
    emit("op6_next", 8'd7);
    clear_err();
`endif

    // Overflow at full depth
    for (int i = 1; i <= 16; i++) push_val(8'(i));
    chk("full_depth", {27'd0, depth}, 16);
    chk("full_no_err", {31'd0, err}, 0);
    p0 = push_cnt;
    send(1'b0, 8'hAA);
    wait_idle("ovf_done");
    chk("ovf_err", {29'd0, err, err_code}, {29'd0, 1'b1, 2'd2});
    chk("ovf_depth", {27'd0, depth}, 16);
    chk("ovf_no_push", push_cnt - p0, 0);
    emit("ovf_emit_16", 8'h10);
    chk("ovf_depth_after", {27'd0, depth}, 15);

    // Reset during POP_A
    send(1'b1, 8'd0);
    cyc();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_strobes", {30'd0, stk_push, stk_pop}, 0);
    chk("mid_rst_din", {24'd0, stk_din}, 0);
    chk("mid_rst_res", {23'd0, res_valid, res_data}, 0);
    chk("mid_rst_depth", {27'd0, depth}, 0);
    chk("mid_rst_err", {29'd0, err, err_code}, 0);
    chk("mid_rst_ready", {31'd0, tok_ready}, 0);
    #2;
    reset_n = 1'b1;
    cyc();
    chk("post_rst_ready", {31'd0, tok_ready}, 1);
    push_val(8'd5);
    emit("post_rst_emit", 8'd5);
    chk("post_rst_depth", {27'd0, depth}, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
